// File: rtl/loctag_pkg.sv
// Shared encodings and constants for the loctag backscatter frame sequencer.
package loctag_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FORCE    = 3'd1,
    S_TONE     = 3'd2,
    S_CAPTURE  = 3'd3,
    S_PREAMBLE = 3'd4,
    S_DATA     = 3'd5,
    S_CRC      = 3'd6,
    S_WAIT_END = 3'd7
  } state_t;

  localparam logic [1:0]  MODE_TONE  = 2'b01;
  localparam logic [1:0]  MODE_DATA  = 2'b10;

  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
  localparam int          CRC_BITS   = 32;

  // Width of the clk-per-microsecond divider, never narrower than one bit.
  function automatic int div_w(input int clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/loctag_crc32_ser.sv
// Serial CRC-32 (poly 0x04C11DB7, zero init, no final XOR): absorbs payload bits, then shifts itself out MSB first.
module loctag_crc32_ser
  import loctag_pkg::*;
(
  input  logic clk,
  input  logic clear,
  input  logic bit_en,
  input  logic d_in,
  input  logic shift_out,
  output logic crc_msb
);

  logic [31:0] crc;

  always_ff @(posedge clk) begin
    if (clear) begin
      crc <= '0;
    end else if (bit_en) begin
      crc <= {crc[30:0], 1'b0} ^ ((crc[31] ^ d_in) ? CRC32_POLY : 32'd0);
    end else if (shift_out) begin
      crc <= {crc[30:0], 1'b0};
    end
  end

  assign crc_msb = crc[31];

endmodule

// File: rtl/loctag_frame_seq.sv
// Backscatter frame sequencer: sensor capture, preamble, then payload + CRC-32 as a DBPSK invert stream at 1 bit/us.
module loctag_frame_seq
  import loctag_pkg::*;
#(
  parameter int CLKS_PER_US   = 50,
  parameter int ADDR_W        = 6,
  parameter int PAYLOAD_BYTES = 34,
  parameter int SENSOR_ADDR   = 26,
  parameter int SENSOR_BYTES  = 1,
  parameter int INFO_US       = 3,
  parameter int MOD_START_US  = 462,
  parameter int TIMER_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trig,
  input  logic              force_fs,
  input  logic [1:0]        mode,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [7:0]        cfg_data,
  output logic              cfg_err,
  output logic              sensor_req,
  input  logic              sensor_valid,
  input  logic [7:0]        sensor_data,
  output logic              sensor_stale,
  output logic              fs_en,
  output logic              mod_invert,
  output logic              busy,
  output logic [2:0]        state_o
);

  localparam int DIV_W = div_w(CLKS_PER_US);
  localparam int CNT_W = ADDR_W + 1;

  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(CLKS_PER_US - 1);
  localparam logic [TIMER_W-1:0] INFO_LAST = TIMER_W'(INFO_US - 1);
  localparam logic [TIMER_W-1:0] PRE_LAST  = TIMER_W'(MOD_START_US - 1);
  localparam logic [TIMER_W-1:0] DATA_LAST = TIMER_W'(8 * PAYLOAD_BYTES - 1);
  localparam logic [TIMER_W-1:0] CRC_LAST  = TIMER_W'(CRC_BITS - 1);
  localparam logic [CNT_W-1:0]   SENS_N    = CNT_W'(SENSOR_BYTES);
  localparam logic [ADDR_W:0]    PAY_N     = (ADDR_W + 1)'(PAYLOAD_BYTES);
  localparam logic [ADDR_W-1:0]  SENS_BASE = ADDR_W'(SENSOR_ADDR);

  state_t             state, state_next;
  logic               trig_m, trig_s;
  logic [DIV_W-1:0]   div;
  logic [TIMER_W-1:0] us_cnt;
  logic               us_tick, period_start, entry;

  logic [7:0]         buffer [2**ADDR_W];
  logic [CNT_W-1:0]   cap_cnt, cap_cnt_nx;
  logic [ADDR_W-1:0]  cap_addr;
  logic               req_open, cap_hold, cap_we, req_d;
  logic               cfg_ok, cfg_err_d;
  logic               data_bit, data_adv, crc_adv, crc_clear, crc_msb;
  logic               fs_en_d, inv_d;

  // Trigger synchroniser stages
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_m <= 1'b0;
      trig_s <= 1'b0;
    end else begin
      trig_m <= trig;
      trig_s <= trig_m;
    end
  end

  // State register and per-state microsecond timer
  assign us_tick      = (div == DIV_LAST);
  assign period_start = (div == '0);
  assign entry        = (state_next != state);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      div    <= '0;
      us_cnt <= '0;
    end else begin
      state <= state_next;
      if (entry || us_tick) div <= '0;
      else                  div <= div + DIV_W'(1);
      if (entry)        us_cnt <= '0;
      else if (us_tick) us_cnt <= us_cnt + TIMER_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    if (force_fs) begin
      state_next = S_FORCE;
    end else if (!trig_s) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (mode == MODE_DATA)      state_next = S_CAPTURE;
          else if (mode == MODE_TONE) state_next = S_TONE;
        end
        S_FORCE:    state_next = S_IDLE;
        S_TONE:     state_next = S_TONE;
        S_CAPTURE:  if (us_tick && us_cnt == INFO_LAST) state_next = S_PREAMBLE;
        S_PREAMBLE: if (us_tick && us_cnt == PRE_LAST)  state_next = S_DATA;
        S_DATA:     if (us_tick && us_cnt == DATA_LAST) state_next = S_CRC;
        S_CRC:      if (us_tick && us_cnt == CRC_LAST)  state_next = S_WAIT_END;
        S_WAIT_END: state_next = S_WAIT_END;
        default:    state_next = S_IDLE;
      endcase
    end
  end

  // In DATA the microsecond count doubles as the payload bit index.
  assign data_bit  = buffer[us_cnt[ADDR_W+2:3]][us_cnt[2:0]];
  assign cap_addr  = SENS_BASE + cap_cnt[ADDR_W-1:0];
  assign crc_clear = (state_next == S_DATA) && (state != S_DATA);

  always_comb begin
    cfg_ok     = cfg_we && (state == S_IDLE) && ({1'b0, cfg_addr} < PAY_N);
    cfg_err_d  = cfg_we && !cfg_ok;
    cap_hold   = (state == S_CAPTURE) &&
                 (state_next == S_CAPTURE || state_next == S_PREAMBLE);
    cap_we     = cap_hold && req_open && sensor_valid;
    cap_cnt_nx = cap_we ? cap_cnt + CNT_W'(1) : cap_cnt;
    req_d      = ((state_next == S_CAPTURE) && (state != S_CAPTURE) && (SENS_N != '0)) ||
                 (cap_we && (state_next == S_CAPTURE) && (cap_cnt_nx < SENS_N));
    data_adv   = (state == S_DATA) && period_start &&
                 (state_next == S_DATA || state_next == S_CRC);
    crc_adv    = (state == S_CRC) && period_start &&
                 (state_next == S_CRC || state_next == S_WAIT_END);
    fs_en_d    = (state_next != S_IDLE);
    inv_d      = 1'b0;
    if (state_next == S_DATA || state_next == S_CRC || state_next == S_WAIT_END)
      inv_d = mod_invert ^ (data_adv & data_bit) ^ (crc_adv & crc_msb);
  end

  loctag_crc32_ser u_crc (
    .clk       (clk),
    .clear     (crc_clear),
    .bit_en    (data_adv),
    .d_in      (data_bit),
    .shift_out (crc_adv),
    .crc_msb   (crc_msb)
  );

  // Capture bookkeeping and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_cnt      <= '0;
      req_open     <= 1'b0;
      sensor_stale <= 1'b0;
      fs_en        <= 1'b0;
      mod_invert   <= 1'b0;
      sensor_req   <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      cap_cnt <= entry ? '0 : cap_cnt_nx;
      if (req_d)                                  req_open <= 1'b1;
      else if (cap_we || state_next != S_CAPTURE) req_open <= 1'b0;
      if (state == S_CAPTURE && state_next == S_PREAMBLE)
        sensor_stale <= (cap_cnt_nx < SENS_N);
      fs_en      <= fs_en_d;
      mod_invert <= inv_d;
      sensor_req <= req_d;
      cfg_err    <= cfg_err_d;
    end
  end

  // Payload buffer keeps its contents across reset
  always_ff @(posedge clk) begin
    if (cap_we)      buffer[cap_addr] <= sensor_data;
    else if (cfg_ok) buffer[cfg_addr] <= cfg_data;
  end

  assign busy    = (state != S_IDLE);
  assign state_o = state;

endmodule

// File: tb/tb_loctag_frame_seq.sv
// Randomised frame bench: a behavioural buffer/stream model predicts the DBPSK invert sequence of every frame.
module tb_loctag_frame_seq;
  import loctag_pkg::*;

  localparam int CLK_US = 4;
  localparam int AW     = 6;
  localparam int PB     = 4;
  localparam int SA     = 2;
  localparam int SB     = 2;
  localparam int INFO   = 3;
  localparam int MOD    = 10;
  localparam int TW     = 16;
  localparam int NBITS  = 8 * PB + 32;

  logic          clk = 1'b0;
  logic          reset, trig, force_fs, cfg_we;
  logic [1:0]    mode;
  logic [AW-1:0] cfg_addr;
  logic [7:0]    cfg_data, sensor_data;
  logic          cfg_err, sensor_req, sensor_valid, sensor_stale;
  logic          fs_en, mod_invert, busy;
  logic [2:0]    state_o;

  int   n_chk = 0;
  int   n_fail = 0;
  logic [7:0] mdl_buf [PB];
  logic [7:0] sens_bytes [SB];
  int   resp_idx = 0;
  bit   ans_en = 1'b0;

  always #5 clk = ~clk;

  loctag_frame_seq #(
    .CLKS_PER_US(CLK_US), .ADDR_W(AW), .PAYLOAD_BYTES(PB), .SENSOR_ADDR(SA),
    .SENSOR_BYTES(SB), .INFO_US(INFO), .MOD_START_US(MOD), .TIMER_W(TW)
  ) dut (
    .clk(clk), .reset(reset), .trig(trig), .force_fs(force_fs), .mode(mode),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
    .sensor_req(sensor_req), .sensor_valid(sensor_valid), .sensor_data(sensor_data),
    .sensor_stale(sensor_stale), .fs_en(fs_en), .mod_invert(mod_invert),
    .busy(busy), .state_o(state_o)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Sensor that answers each request after 0..2 cycles while enabled
  initial begin
    sensor_valid = 1'b0;
    sensor_data  = 8'h00;
    forever begin
      @(negedge clk);
      sensor_valid = 1'b0;
      if (sensor_req && ans_en && resp_idx < SB) begin
        repeat ($urandom_range(2, 0)) @(negedge clk);
        sensor_data  = sens_bytes[resp_idx];
        resp_idx++;
        sensor_valid = 1'b1;
      end
    end
  end

  function automatic logic [31:0] crc_model();
    logic [31:0] c;
    logic d;
    c = 32'd0;
    for (int n = 0; n < 8 * PB; n++) begin
      d = mdl_buf[n / 8][n % 8];
      c = {c[30:0], 1'b0} ^ ((c[31] ^ d) ? 32'h04C11DB7 : 32'd0);
    end
    return c;
  endfunction

  task automatic cfg_write(input int addr, input logic [7:0] data);
    cfg_we   = 1'b1;
    cfg_addr = AW'(addr);
    cfg_data = data;
    step(1);
    chk_eq($sformatf("cfg_err_a%0d", addr), cfg_err, (addr >= PB));
    if (addr < PB) mdl_buf[addr] = data;
    cfg_we = 1'b0;
  endtask

  // abort_kind: 0 none, 1 trig drop, 2 force_fs plus a cfg write attempt; abort_at = bit index
  task automatic run_frame(input bit ans, input int abort_kind, input int abort_at);
    logic [31:0]      crc;
    logic [NBITS-1:0] stream;
    logic             exp_inv;
    int               a;
    for (int k = 0; k < SB; k++) sens_bytes[k] = 8'($urandom);
    resp_idx = 0;
    ans_en   = ans;
    mode     = 2'b10;
    trig     = 1'b1;
    step(3);
    chk_eq("cap_state", 32'(state_o), 32'(S_CAPTURE));
    chk_eq("cap_req", sensor_req, 1'b1);
    chk_eq("cap_fs_en", fs_en, 1'b1);
    step(INFO * CLK_US);
    chk_eq("pre_state", 32'(state_o), 32'(S_PREAMBLE));
    chk_eq("stale", sensor_stale, !ans);
    chk_eq("pre_inv", mod_invert, 1'b0);
    if (ans) for (int k = 0; k < SB; k++) mdl_buf[SA + k] = sens_bytes[k];
    crc = crc_model();
    for (int n = 0; n < 8 * PB; n++) stream[n] = mdl_buf[n / 8][n % 8];
    for (int j = 0; j < 32; j++) stream[8 * PB + j] = crc[31 - j];
    step(MOD * CLK_US);
    chk_eq("data_state", 32'(state_o), 32'(S_DATA));
    exp_inv = 1'b0;
    for (int n = 0; n < NBITS; n++) begin
      exp_inv ^= stream[n];
      step(2);
      chk_eq($sformatf("inv_bit%0d", n), mod_invert, exp_inv);
      if (abort_kind != 0 && n == abort_at) begin
        if (abort_kind == 1) begin
          trig = 1'b0;
          step(3);
          chk_eq("drop_state", 32'(state_o), 32'(S_IDLE));
          chk_eq("drop_fs_en", fs_en, 1'b0);
          chk_eq("drop_inv", mod_invert, 1'b0);
        end else begin
          a        = $urandom_range(PB - 1, 0);
          force_fs = 1'b1;
          cfg_we   = 1'b1;
          cfg_addr = AW'(a);
          cfg_data = ~mdl_buf[a];
          step(1);
          cfg_we = 1'b0;
          chk_eq("force_state", 32'(state_o), 32'(S_FORCE));
          chk_eq("force_fs_en", fs_en, 1'b1);
          chk_eq("force_inv", mod_invert, 1'b0);
          chk_eq("busy_cfg_err", cfg_err, 1'b1);
          step(4);
          chk_eq("force_hold_fs", fs_en, 1'b1);
          chk_eq("force_hold_inv", mod_invert, 1'b0);
          trig = 1'b0;
          step(3);
          force_fs = 1'b0;
          step(1);
          chk_eq("unforce_state", 32'(state_o), 32'(S_IDLE));
          chk_eq("unforce_fs_en", fs_en, 1'b0);
        end
        return;
      end
      step(CLK_US - 2);
    end
    chk_eq("wait_state", 32'(state_o), 32'(S_WAIT_END));
    chk_eq("wait_fs_en", fs_en, 1'b1);
    chk_eq("wait_inv", mod_invert, exp_inv);
    step(7);
    chk_eq("wait_hold_state", 32'(state_o), 32'(S_WAIT_END));
    chk_eq("wait_hold_inv", mod_invert, exp_inv);
    trig = 1'b0;
    step(3);
    chk_eq("end_state", 32'(state_o), 32'(S_IDLE));
    chk_eq("end_fs_en", fs_en, 1'b0);
    chk_eq("end_inv", mod_invert, 1'b0);
    chk_eq("end_busy", busy, 1'b0);
  endtask

  initial begin
    int req_seen, fs_low;
    reset = 1'b1; trig = 1'b0; force_fs = 1'b0; mode = 2'b00;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = 8'h00;
    step(3);
    chk_eq("rst_state", 32'(state_o), 32'(S_IDLE));
    chk_eq("rst_fs_en", fs_en, 1'b0);
    chk_eq("rst_inv", mod_invert, 1'b0);
    chk_eq("rst_busy", busy, 1'b0);
    chk_eq("rst_stale", sensor_stale, 1'b0);
    chk_eq("rst_req", sensor_req, 1'b0);
    chk_eq("rst_cfg_err", cfg_err, 1'b0);
    reset = 1'b0;
    step(2);

    // All-zero payload, silent sensor
    for (int i = 0; i < PB; i++) cfg_write(i, 8'h00);
    cfg_write(PB + int'($urandom_range(63 - PB, 0)), 8'h5A);
    run_frame(1'b0, 0, -1);

    // Single set bit at payload bit 7
    cfg_write(0, 8'h80);
    run_frame(1'b0, 0, -1);

    // Random payloads with sensor answers, aborts and replays
    for (int i = 0; i < PB; i++) cfg_write(i, 8'($urandom));
    run_frame(1'b1, 0, -1);
    run_frame(1'b1, 1, int'($urandom_range(8 * PB - 1, 0)));
    run_frame(1'b0, 0, -1);
    run_frame(1'b1, 2, int'($urandom_range(8 * PB - 1, 0)));
    run_frame(1'b0, 0, -1);

    // Tone-only mode
    mode = 2'b01;
    trig = 1'b1;
    step(3);
    chk_eq("tone_state", 32'(state_o), 32'(S_TONE));
    req_seen = 0;
    fs_low   = 0;
    for (int i = 0; i < 20; i++) begin
      if (sensor_req) req_seen++;
      if (!fs_en || mod_invert) fs_low++;
      step(1);
    end
    chk_eq("tone_no_req", req_seen, 0);
    chk_eq("tone_fs_steady", fs_low, 0);
    trig = 1'b0;
    step(3);
    chk_eq("tone_end_state", 32'(state_o), 32'(S_IDLE));

    // Reserved mode stays idle
    mode = 2'b11;
    trig = 1'b1;
    step(10);
    chk_eq("mode11_state", 32'(state_o), 32'(S_IDLE));
    chk_eq("mode11_fs_en", fs_en, 1'b0);
    trig = 1'b0;
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
